// File: rtl/sram_controller_pkg.sv
// Shared types for the external SRAM controller: chip word address, byte mask, data word
// and the access state machine encoding.
package sram_controller_pkg;

    localparam int unsigned SramAddrWidth = 20;
    localparam int unsigned CntWidth      = 4;

    typedef logic [SramAddrWidth-1:0] SramChipAddress_t;
    typedef logic [3:0]               ByteMask_t;
    typedef logic [31:0]              Word_t;
    typedef logic [CntWidth-1:0]      SramCount_t;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWSetup,
        StWPulse,
        StWHold,
        StDone
    } SramCtrlState_t;

endpackage

// File: rtl/sram_controller.sv
// Bus slave that runs single-word reads/writes as timed strobe cycles on a 32-bit
// asynchronous SRAM, stalling the master until the chip cycle has completed.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned READ_CYCLES  = 2,
    parameter int unsigned WRITE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      bus_address,
    input  logic             bus_read,
    input  logic             bus_write,
    input  logic [31:0]      bus_data_wr,
    input  logic [3:0]       bus_mask,
    output logic             bus_stall,
    output logic [31:0]      bus_data_rd,
    output logic [31:0]      bus_data_rd_2,
    output logic [19:0]      sram_address,
    inout  wire logic [31:0] sram_data,
    output logic [3:0]       sram_be_n,
    output logic             sram_ce_n,
    output logic             sram_oe_n,
    output logic             sram_we_n
);

    localparam SramCount_t ReadLast  = SramCount_t'(READ_CYCLES - 1);
    localparam SramCount_t WriteLast = SramCount_t'(WRITE_CYCLES - 1);

    SramCtrlState_t   state_q, state_d;
    SramCount_t       count_q, count_d;
    SramChipAddress_t addr_q, addr_d;
    Word_t            wdata_q, wdata_d;
    Word_t            rdata_q, rdata_d;
    ByteMask_t        mask_q, mask_d;
    logic             drive_data;

    // Upper bits are decoded upstream; the byte offset is replaced by byte enables.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus_address[31:22], bus_address[1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mask_d  = mask_q;
        unique case (state_q)
            StIdle: begin
                count_d = '0;
                if (bus_write) begin
                    state_d = StWSetup;
                    addr_d  = bus_address[21:2];
                    wdata_d = bus_data_wr;
                    mask_d  = bus_mask;
                end else if (bus_read) begin
                    state_d = StRead;
                    addr_d  = bus_address[21:2];
                end
            end
            StRead: begin
                if (count_q == ReadLast) begin
                    rdata_d = sram_data;
                    count_d = '0;
                    state_d = StDone;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            StWSetup: begin
                count_d = '0;
                state_d = StWPulse;
            end
            StWPulse: begin
                if (count_q == WriteLast) begin
                    count_d = '0;
                    state_d = StWHold;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            StWHold: begin
                count_d = '0;
                state_d = StDone;
            end
            StDone: begin
                count_d = '0;
                state_d = StIdle;
            end
            default: begin
                count_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_be_n  = 4'b1111;
        drive_data = 1'b0;
        unique case (state_q)
            StRead: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_be_n = 4'b0000;
            end
            StWSetup, StWHold: begin
                sram_ce_n  = 1'b0;
                sram_be_n  = ~mask_q;
                drive_data = 1'b1;
            end
            StWPulse: begin
                sram_ce_n  = 1'b0;
                sram_we_n  = 1'b0;
                sram_be_n  = ~mask_q;
                drive_data = 1'b1;
            end
            default: begin
                sram_ce_n = 1'b1;
            end
        endcase
    end

    assign sram_data     = drive_data ? wdata_q : 'z;
    assign sram_address  = addr_q;
    assign bus_data_rd   = rdata_q;
    assign bus_data_rd_2 = '0;
    assign bus_stall     = (bus_read | bus_write) && (state_q != StDone);

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (default and 1/15 strobe widths), each with a
// behavioural SRAM chip, checked against directed vectors and a word-level memory model.
module tb_sram_controller;

    localparam int RA = 2;
    localparam int WA = 2;
    localparam int RB = 1;
    localparam int WB = 15;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        req_rd, req_wr;
    logic [31:0] b_addr, b_wdata;
    logic [3:0]  b_mask;

    logic        stall_a, ce_a, oe_a, we_a;
    logic [31:0] rd_a, rd2_a;
    logic [19:0] addr_a;
    logic [3:0]  be_a;
    wire  [31:0] data_a;

    logic        stall_b, ce_b, oe_b, we_b;
    logic [31:0] rd_b, rd2_b;
    logic [19:0] addr_b;
    logic [3:0]  be_b;
    wire  [31:0] data_b;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    sram_controller u_dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus_address  (b_addr),
        .bus_read     (req_rd & ~sel),
        .bus_write    (req_wr & ~sel),
        .bus_data_wr  (b_wdata),
        .bus_mask     (b_mask),
        .bus_stall    (stall_a),
        .bus_data_rd  (rd_a),
        .bus_data_rd_2(rd2_a),
        .sram_address (addr_a),
        .sram_data    (data_a),
        .sram_be_n    (be_a),
        .sram_ce_n    (ce_a),
        .sram_oe_n    (oe_a),
        .sram_we_n    (we_a)
    );

    sram_controller #(
        .READ_CYCLES (RB),
        .WRITE_CYCLES(WB)
    ) u_dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus_address  (b_addr),
        .bus_read     (req_rd & sel),
        .bus_write    (req_wr & sel),
        .bus_data_wr  (b_wdata),
        .bus_mask     (b_mask),
        .bus_stall    (stall_b),
        .bus_data_rd  (rd_b),
        .bus_data_rd_2(rd2_b),
        .sram_address (addr_b),
        .sram_data    (data_b),
        .sram_be_n    (be_b),
        .sram_ce_n    (ce_b),
        .sram_oe_n    (oe_b),
        .sram_we_n    (we_b)
    );

    // Behavioural chips; an undriven data bus floats to all ones.
    logic [31:0] mem_a [0:1048575];
    logic [31:0] mem_b [0:1048575];
    pullup pu_a (data_a);
    pullup pu_b (data_b);
    assign data_a = (!ce_a && !oe_a && we_a) ? mem_a[addr_a] : 'z;
    assign data_b = (!ce_b && !oe_b && we_b) ? mem_b[addr_b] : 'z;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        for (int i = 0; i < 4; i++) begin
            if (!ce_a && !we_a && !be_a[i]) mem_a[addr_a][8*i +: 8] <= data_a[8*i +: 8];
            if (!ce_b && !we_b && !be_b[i]) mem_b[addr_b][8*i +: 8] <= data_b[8*i +: 8];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire        m_stall = sel ? stall_b : stall_a;
    wire        m_ce    = sel ? ce_b : ce_a;
    wire        m_oe    = sel ? oe_b : oe_a;
    wire        m_we    = sel ? we_b : we_a;
    wire [3:0]  m_be    = sel ? be_b : be_a;
    wire [19:0] m_addr  = sel ? addr_b : addr_a;
    wire [31:0] m_rdata = sel ? rd_b : rd_a;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        int          stall;
        int          oe_low;
        int          we_low;
        logic [3:0]  be;
        logic [19:0] waddr;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        int          stall;
        int          oe_low;
        int          we_low;
        logic [3:0]  be;
        logic [19:0] addr;
        logic [31:0] rdata;
        int          done_cyc;
        bit          stable;
        bit          done;
    } acc_t;

    logic [31:0] ref_a [int unsigned];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void ref_write(input int unsigned w, input logic [31:0] d,
                                      input logic [3:0] m);
        logic [31:0] v;
        v = ref_a.exists(w) ? ref_a[w] : 32'h0;
        for (int i = 0; i < 4; i++) if (m[i]) v[8*i +: 8] = d[8*i +: 8];
        ref_a[w] = v;
    endfunction

    // Called 1 time unit after a rising edge; returns 1 unit after the edge following DONE
    // with the request still asserted.
    task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] mask, output acc_t res);
        bit          seen;
        logic [19:0] first;
        seen = 0;
        first = '0;
        res = '{stall: 0, oe_low: 0, we_low: 0, be: 4'hF, addr: '0, rdata: '0,
                done_cyc: 0, stable: 1'b1, done: 1'b0};
        req_wr = wr;
        req_rd = rd;
        b_addr = addr;
        b_wdata = data;
        b_mask = mask;
        #1;
        for (int i = 0; i < 64; i++) begin
            if (!m_ce) begin
                if (!seen) begin
                    seen = 1;
                    first = m_addr;
                end else if (m_addr != first) begin
                    res.stable = 0;
                end
            end
            if (!m_oe) res.oe_low++;
            if (!m_we) begin
                res.we_low++;
                res.be = m_be;
            end
            if (!m_stall) begin
                res.done = 1;
                res.rdata = m_rdata;
                res.addr = m_addr;
                res.done_cyc = cycle;
                if (seen && m_addr != first) res.stable = 0;
                break;
            end
            res.stall++;
            @(posedge clk);
            #2;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input string name, input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] mask, input int e_stall,
                         input int e_oe, input int e_we, input logic [3:0] e_be,
                         input logic [19:0] e_addr, input logic [31:0] e_rd);
        acc_t r;
        access(wr, rd, addr, data, mask, r);
        check({name, ".done"}, 32'(r.done), 32'd1);
        check({name, ".stall"}, r.stall, e_stall);
        check({name, ".oe_low"}, r.oe_low, e_oe);
        check({name, ".we_low"}, r.we_low, e_we);
        check({name, ".be_n"}, 32'(r.be), 32'(e_be));
        check({name, ".addr"}, 32'(r.addr), 32'(e_addr));
        check({name, ".addr_stable"}, 32'(r.stable), 32'd1);
        check({name, ".rdata"}, r.rdata, e_rd);
    endtask

    task automatic idle();
        req_rd = 0;
        req_wr = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string name);
        check({name, ".ce_n"}, 32'(m_ce), 32'd1);
        check({name, ".oe_n"}, 32'(m_oe), 32'd1);
        check({name, ".we_n"}, 32'(m_we), 32'd1);
        check({name, ".be_n"}, 32'(m_be), 32'hF);
        check({name, ".stall"}, 32'(m_stall), 32'd0);
        check({name, ".data_z"}, data_a, 32'hFFFF_FFFF);
    endtask

    vec_t tbl [12];

    initial begin
        acc_t        r0, r1;
        logic [31:0] r, data, exp_rd, last_rd;
        logic [3:0]  mask;
        logic [19:0] word;
        logic [31:0] addr;
        int          kind;

        tbl[0]  = '{1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 5, 0, 2, 4'h0, 20'h4, 32'h0};
        tbl[1]  = '{0, 1, 32'h0000_0010, 32'h0, 4'h0, 3, 2, 0, 4'hF, 20'h4, 32'hDEAD_BEEF};
        tbl[2]  = '{1, 0, 32'h0000_0010, 32'h1122_3344, 4'h2, 5, 0, 2, 4'hD, 20'h4, 32'hDEAD_BEEF};
        tbl[3]  = '{0, 1, 32'h0000_0010, 32'h0, 4'h0, 3, 2, 0, 4'hF, 20'h4, 32'hDEAD_33EF};
        tbl[4]  = '{1, 1, 32'h0000_0020, 32'hCAFE_0001, 4'hF, 5, 0, 2, 4'h0, 20'h8, 32'hDEAD_33EF};
        tbl[5]  = '{0, 1, 32'h0000_0020, 32'h0, 4'h0, 3, 2, 0, 4'hF, 20'h8, 32'hCAFE_0001};
        tbl[6]  = '{1, 0, 32'h0000_0020, 32'h1234_5678, 4'h0, 5, 0, 2, 4'hF, 20'h8, 32'hCAFE_0001};
        tbl[7]  = '{0, 1, 32'h0000_0020, 32'h0, 4'h0, 3, 2, 0, 4'hF, 20'h8, 32'hCAFE_0001};
        tbl[8]  = '{1, 0, 32'hFF00_0044, 32'h0BAD_F00D, 4'hF, 5, 0, 2, 4'h0, 20'h11, 32'hCAFE_0001};
        tbl[9]  = '{0, 1, 32'h0000_0047, 32'h0, 4'h0, 3, 2, 0, 4'hF, 20'h11, 32'h0BAD_F00D};
        tbl[10] = '{1, 0, 32'h003F_FFFC, 32'hA5A5_0F0F, 4'hF, 5, 0, 2, 4'h0, 20'hFFFFF, 32'h0BAD_F00D};
        tbl[11] = '{1, 0, 32'h0000_0000, 32'h5A5A_F0F0, 4'hF, 5, 0, 2, 4'h0, 20'h0, 32'h0BAD_F00D};

        rst_n = 0;
        sel = 0;
        req_rd = 0;
        req_wr = 0;
        b_addr = '0;
        b_wdata = '0;
        b_mask = '0;
        repeat (3) @(posedge clk);
        #2;
        check_quiet("reset");
        check("reset.addr", 32'(addr_a), 32'h0);
        check("reset.rdata", rd_a, 32'h0);
        check("reset.rd2", rd2_a, 32'h0);
        rst_n = 1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            apply($sformatf("vec%0d", i), tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data,
                  tbl[i].mask, tbl[i].stall, tbl[i].oe_low, tbl[i].we_low, tbl[i].be,
                  tbl[i].waddr, tbl[i].rdata);
            if (tbl[i].wr) ref_write(32'(tbl[i].addr[21:2]), tbl[i].data, tbl[i].mask);
            idle();
        end

        // Back-to-back reads: the second request is already present in the IDLE after DONE.
        access(0, 1, 32'h003F_FFFC, 32'h0, 4'h0, r0);
        access(0, 1, 32'h0000_0000, 32'h0, 4'h0, r1);
        idle();
        check("b2b.addr0", 32'(r0.addr), 32'h000F_FFFF);
        check("b2b.rdata0", r0.rdata, 32'hA5A5_0F0F);
        check("b2b.addr1", 32'(r1.addr), 32'h0);
        check("b2b.rdata1", r1.rdata, 32'h5A5A_F0F0);
        check("b2b.done_gap", r1.done_cyc - r0.done_cyc, RA + 2);
        check("b2b.stall1", r1.stall, RA + 1);
        last_rd = 32'h5A5A_F0F0;

        for (int n = 0; n < 40; n++) begin
            r = $urandom();
            word = 20'h00100 + 20'(r[9:6]);
            addr = {r[31:22], word, r[5:4]};
            kind = $urandom_range(0, 3);
            if (kind == 2 && !ref_a.exists(32'(word))) kind = 0;
            mask = 4'($urandom());
            if (!ref_a.exists(32'(word))) mask = 4'hF;
            data = $urandom();
            if (kind == 2) begin
                exp_rd = ref_a[32'(word)];
                apply("rnd_rd", 0, 1, addr, data, mask, RA + 1, RA, 0, 4'hF, word, exp_rd);
                last_rd = exp_rd;
            end else begin
                apply("rnd_wr", 1, kind == 3, addr, data, mask, WA + 3, 0, WA, ~mask, word,
                      last_rd);
                ref_write(32'(word), data, mask);
            end
            idle();
        end

        sel = 1;
        idle();
        apply("slow_wr", 1, 0, 32'h0000_0100, 32'h55AA_1234, 4'hF, WB + 3, 0, WB, 4'h0,
              20'h40, 32'h0);
        idle();
        apply("slow_rd", 0, 1, 32'h0000_0100, 32'h0, 4'h0, RB + 1, RB, 0, 4'hF, 20'h40,
              32'h55AA_1234);
        idle();
        check("slow.rd2", rd2_b, 32'h0);
        sel = 0;
        idle();

        // Reset in the middle of a write pulse aborts the chip cycle.
        req_wr = 1;
        b_addr = 32'h0000_0030;
        b_wdata = 32'h0F0F_0F0F;
        b_mask = 4'hF;
        repeat (2) @(posedge clk);
        #2;
        check("rst_mid.in_pulse", 32'(we_a), 32'd0);
        rst_n = 0;
        req_wr = 0;
        @(posedge clk);
        #2;
        check_quiet("rst_mid.first");
        repeat (2) @(posedge clk);
        rst_n = 1;
        @(posedge clk);
        #2;
        check_quiet("rst_mid.after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
